// File: rtl/load_return_queue.sv
// Purpose : in-order tracker of outstanding data-bus requests; formats returned load data.
// Latency : rd_valid/rd_data one cycle after data_ok; full/count/data_pending one cycle after the update.
// Backpr. : upstream must hold off req while full; an enqueue while full is dropped and flagged on err.
//
// Ports   : clk, rst (async active-low) | req, addr_ok, we, ofs, width, sign, tag: request side
//           data_ok, rdata: bus return | rd_valid, rd_data, rd_tag, rd_we, rd_misalign: completion
//           full, data_pending, count: occupancy | err: sticky protocol-violation flag
// Macro   : LRQ_MISALIGN_CHK_EN -- zero the result and raise rd_misalign on misaligned half/word loads.
module load_return_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   addr_ok,
  input  logic                   we,
  input  logic [1:0]             ofs,
  input  logic [1:0]             width,
  input  logic                   sign,
  input  logic [TAG_W-1:0]       tag,
  input  logic                   data_ok,
  input  logic [31:0]            rdata,
  output logic                   rd_valid,
  output logic [31:0]            rd_data,
  output logic [TAG_W-1:0]       rd_tag,
  output logic                   rd_we,
  output logic                   rd_misalign,
  output logic                   full,
  output logic                   data_pending,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic             we;
    logic [1:0]       ofs;
    logic [1:0]       width;
    logic             sign;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [TAG_W-1:0] rd_tag_q, rd_tag_d;
  logic             rd_we_q, rd_we_d;
  logic             rd_misalign_q, rd_misalign_d;

  logic             is_full, is_empty, enq_req, enq_fire, deq_fire;
  entry_t           head;
  logic [31:0]      lane;
  logic [31:0]      load_val;
  logic             load_mis;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign enq_req  = req && addr_ok;
  // A dequeue in the same cycle frees the slot, so a full-queue enqueue is still legal then.
  assign enq_fire = enq_req && (!is_full || data_ok);
  assign deq_fire = data_ok && !is_empty;
  assign head     = mem_q[rd_ptr_q];
  // Shift the addressed byte/halfword down to bit 0.
  assign lane     = rdata >> {head.ofs, 3'b000};

  always_comb begin
    load_val = '0;
    load_mis = 1'b0;
    case (head.width)
      2'b01: load_val = {{24{head.sign & lane[7]}}, lane[7:0]};
      2'b10: begin
        if (head.ofs[0]) begin
          load_val = '0;
`ifdef LRQ_MISALIGN_CHK_EN
          load_mis = 1'b1;
`endif
        end else begin
          load_val = {{16{head.sign & lane[15]}}, lane[15:0]};
        end
      end
      2'b11: begin
`ifdef LRQ_MISALIGN_CHK_EN
        if (head.ofs != 2'b00) begin
          load_val = '0;
          load_mis = 1'b1;
        end else begin
          load_val = rdata;
        end
`else
        load_val = rdata;
`endif
      end
      default: load_val = '0;
    endcase
  end

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    err_d         = err_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    rd_tag_d      = rd_tag_q;
    rd_we_d       = rd_we_q;
    rd_misalign_d = rd_misalign_q;

    if ((enq_req && is_full && !data_ok) || (data_ok && is_empty)) begin
      err_d = 1'b1;
    end

    if (enq_fire) begin
      mem_d[wr_ptr_q] = '{we: we, ofs: ofs, width: width, sign: sign, tag: tag};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (deq_fire) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      rd_valid_d = 1'b1;
      rd_tag_d   = head.tag;
      rd_we_d    = head.we;
      // Stores complete with a pulse only; the last load result stays visible.
      if (!head.we) begin
        rd_data_d     = load_val;
        rd_misalign_d = load_mis;
      end else begin
        rd_misalign_d = 1'b0;
      end
    end

    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_tag_q      <= '0;
      rd_we_q       <= 1'b0;
      rd_misalign_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_q         <= err_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      rd_tag_q      <= rd_tag_d;
      rd_we_q       <= rd_we_d;
      rd_misalign_q <= rd_misalign_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_tag       = rd_tag_q;
  assign rd_we        = rd_we_q;
  assign rd_misalign  = rd_misalign_q;
  assign full         = is_full;
  assign data_pending = !is_empty;
  assign count        = count_q;
  assign err          = err_q;

endmodule

// File: tb/tb_load_return_queue.sv
// Purpose : self-checking bench for load_return_queue (DEPTH=4, TAG_W=5).
// Timing  : inputs change 1 time unit after a rising edge; outputs are compared 1 unit after the next edge.
// Model   : a queue of request records plus the byte-lane rules expressed arithmetically.
module tb_load_return_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
`ifdef LRQ_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req = 1'b0, addr_ok = 1'b0, we = 1'b0, sign = 1'b0, data_ok = 1'b0;
  logic [1:0]       ofs = '0, width = '0;
  logic [TAG_W-1:0] tag = '0;
  logic [31:0]      rdata = '0;
  logic             rd_valid, rd_we, rd_misalign, full, data_pending, err;
  logic [31:0]      rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic [2:0]       count;

  load_return_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_ok(addr_ok), .we(we), .ofs(ofs), .width(width),
    .sign(sign), .tag(tag), .data_ok(data_ok), .rdata(rdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_tag(rd_tag), .rd_we(rd_we), .rd_misalign(rd_misalign),
    .full(full), .data_pending(data_pending), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       we;
    int       ofs;
    int       width;
    bit       sign;
    int       tag;
  } req_t;

  req_t        mq[$];
  bit          m_err, m_valid, m_we, m_mis;
  logic [31:0] m_data;
  int          m_tag;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] model_data(req_t e, logic [31:0] rd);
    longint unsigned v;
    case (e.width)
      1: begin
        v = (longint'(rd) >> (8 * e.ofs)) % 256;
        if (e.sign && v >= 128) v = v + 64'hFFFF_FF00;
      end
      2: begin
        if (e.ofs % 2 == 1) v = 0;
        else begin
          v = (longint'(rd) >> (8 * e.ofs)) % 65536;
          if (e.sign && v >= 32768) v = v + 64'hFFFF_0000;
        end
      end
      3: v = (MIS_EN && e.ofs != 0) ? 0 : longint'(rd);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic bit model_mis(req_t e);
    if (!MIS_EN) return 1'b0;
    return (e.width == 2 && e.ofs % 2 == 1) || (e.width == 3 && e.ofs != 0);
  endfunction

  // Drive one cycle of inputs, advance the reference model, then settle past the edge.
  task automatic cyc(input bit r, input bit a, input bit w, input int o, input int wd,
                     input bit s, input int t, input bit dok, input logic [31:0] rd);
    req_t e;
    req = r; addr_ok = a; we = w; ofs = o[1:0]; width = wd[1:0]; sign = s;
    tag = t[TAG_W-1:0]; data_ok = dok; rdata = rd;
    if (dok && mq.size() == 0) m_err = 1'b1;
    if (r && a && mq.size() == DEPTH && !dok) m_err = 1'b1;
    m_valid = 1'b0;
    if (dok && mq.size() > 0) begin
      e = mq.pop_front();
      m_valid = 1'b1;
      m_tag = e.tag;
      m_we = e.we;
      if (!e.we) begin
        m_data = model_data(e, rd);
        m_mis = model_mis(e);
      end else begin
        m_mis = 1'b0;
      end
    end
    if (r && a && mq.size() < DEPTH) begin
      e.we = w; e.ofs = o; e.width = wd; e.sign = s; e.tag = t;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    req = 0; addr_ok = 0; we = 0; ofs = 0; width = 0; sign = 0; tag = 0; data_ok = 0; rdata = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic model_clear();
    mq.delete();
    m_err = 0; m_valid = 0; m_we = 0; m_mis = 0; m_data = 0; m_tag = 0;
  endtask

  // Pulse rst low between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_clear();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({rd_valid, rd_we, rd_misalign, full, data_pending, err} !== 6'b0)
      $display("FAIL reset_flags got=%b want=000000", {rd_valid, rd_we, rd_misalign, full, data_pending, err});
    else n_pass++;
    n_checks++;
    if (count !== 3'd0 || rd_data !== 32'h0 || rd_tag !== '0)
      $display("FAIL reset_values count=%0d data=%h tag=%0d want 0/0/0", count, rd_data, rd_tag);
    else n_pass++;
  endtask

  task automatic test_signed_byte();
    do_reset();
    cyc(1, 1, 0, 3, 1, 1, 3, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h8012_3456);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hFFFF_FF80 || rd_tag !== 5'd3 || count !== 3'd0)
      $display("FAIL lb_signed valid=%b data=%h tag=%0d count=%0d want 1/ffffff80/3/0",
               rd_valid, rd_data, rd_tag, count);
    else n_pass++;
    idle();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hFFFF_FF80)
      $display("FAIL pulse_hold valid=%b data=%h want 0/ffffff80", rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 0, 3, 0, i, 0, 32'h0);
    n_checks++;
    if (full !== 1'b1 || count !== 3'd4 || data_pending !== 1'b1)
      $display("FAIL fill full=%b count=%0d pending=%b want 1/4/1", full, count, data_pending);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1000 + i);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_tag !== i[TAG_W-1:0] || rd_data !== 32'h1000 + i
          || data_pending !== (i != 4))
        $display("FAIL drain_%0d valid=%b tag=%0d data=%h pending=%b want 1/%0d/%h/%b",
                 i, rd_valid, rd_tag, rd_data, data_pending, i, 32'h1000 + i, i != 4);
      else n_pass++;
    end
  endtask

  task automatic test_full_collision();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 3, 0, i + 8, 0, 32'h0);
    cyc(1, 1, 1, 0, 3, 0, 20, 1, 32'h0);
    n_checks++;
    if (count !== 3'd4 || err !== 1'b0 || rd_valid !== 1'b1 || rd_tag !== 5'd8)
      $display("FAIL full_enq_deq count=%0d err=%b valid=%b tag=%0d want 4/0/1/8", count, err, rd_valid, rd_tag);
    else n_pass++;
    cyc(1, 1, 0, 0, 3, 0, 21, 0, 32'h0);
    n_checks++;
    if (count !== 3'd4 || err !== 1'b1)
      $display("FAIL full_drop count=%0d err=%b want 4/1", count, err);
    else n_pass++;
    // The dropped tag 21 must never appear; tag 20 (a store) comes out last.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    n_checks++;
    if (rd_tag !== 5'd20 || rd_we !== 1'b1 || count !== 3'd0)
      $display("FAIL full_tail tag=%0d we=%b count=%0d want 20/1/0", rd_tag, rd_we, count);
    else n_pass++;
  endtask

  task automatic test_empty_data_ok();
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    n_checks++;
    if (rd_valid !== 1'b0 || err !== 1'b1 || count !== 3'd0)
      $display("FAIL empty_dok valid=%b err=%b count=%0d want 0/1/0", rd_valid, err, count);
    else n_pass++;
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 3, 0, 1, 1, 32'h0);
    n_checks++;
    if (err !== 1'b1)
      $display("FAIL err_sticky err=%b want 1", err);
    else n_pass++;
  endtask

  task automatic test_half_word();
    do_reset();
    cyc(1, 1, 0, 2, 2, 0, 6, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_0000);
    n_checks++;
    if (rd_data !== 32'h0000_8001 || rd_misalign !== 1'b0)
      $display("FAIL lhu_hi data=%h mis=%b want 00008001/0", rd_data, rd_misalign);
    else n_pass++;
    cyc(1, 1, 0, 1, 3, 0, 7, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    n_checks++;
    if (rd_data !== (MIS_EN ? 32'h0 : 32'hDEAD_BEEF) || rd_misalign !== MIS_EN)
      $display("FAIL lw_misaligned data=%h mis=%b want %h/%b", rd_data, rd_misalign,
               MIS_EN ? 32'h0 : 32'hDEAD_BEEF, MIS_EN);
    else n_pass++;
    cyc(1, 1, 0, 1, 2, 1, 9, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    n_checks++;
    if (rd_data !== 32'h0 || rd_misalign !== MIS_EN)
      $display("FAIL lh_odd data=%h mis=%b want 00000000/%b", rd_data, rd_misalign, MIS_EN);
    else n_pass++;
  endtask

  task automatic test_random();
    bit r, dok;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom % 2) == 1;
      if (mq.size() == DEPTH && ($urandom % 20) != 0) r = 0;
      dok = ($urandom % 2) == 1;
      if (mq.size() == 0 && ($urandom % 20) != 0) dok = 0;
      cyc(r, ($urandom % 4) != 0, ($urandom % 4) == 0, $urandom % 4, $urandom % 4,
          ($urandom % 2) == 1, $urandom % 32, dok, $urandom);
      n_checks++;
      if (rd_valid !== m_valid || rd_data !== m_data || rd_tag !== m_tag[TAG_W-1:0]
          || rd_we !== m_we || rd_misalign !== m_mis)
        $display("FAIL rand_out_%0d got v=%b d=%h t=%0d w=%b m=%b want v=%b d=%h t=%0d w=%b m=%b",
                 i, rd_valid, rd_data, rd_tag, rd_we, rd_misalign, m_valid, m_data, m_tag, m_we, m_mis);
      else n_pass++;
      n_checks++;
      if (count !== mq.size() || full !== (mq.size() == DEPTH)
          || data_pending !== (mq.size() != 0) || err !== m_err)
        $display("FAIL rand_state_%0d got c=%0d f=%b p=%b e=%b want c=%0d e=%b",
                 i, count, full, data_pending, err, mq.size(), m_err);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 3, 0, i + 1, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h55AA_55AA);
    // Three outstanding, completion pulse currently high.
    #3;
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 32'h0 || rd_tag !== '0
        || data_pending !== 1'b0 || full !== 1'b0)
      $display("FAIL async_clear count=%0d valid=%b data=%h tag=%0d pending=%b full=%b want all 0",
               count, rd_valid, rd_data, rd_tag, data_pending, full);
    else n_pass++;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
    n_checks++;
    if (err !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL post_reset_dok err=%b valid=%b want 1/0", err, rd_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_fill_drain();
    test_full_collision();
    test_empty_data_ok();
    test_half_word();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_return_queue.md
LOAD_RETURN_QUEUE -- requirements
Module: load_return_queue

Interface
REQ-001 Parameter DEPTH, 4, max outstanding bus requests; power of two, 2..16.
REQ-002 Parameter TAG_W, 5, width of destination-register tag carried per request.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  core issues data-bus request this cycle.
REQ-006 addr_ok  in  1  bus accepts address; req&&addr_ok = enqueue.
REQ-007 we  in  1  request is a store.
REQ-008 ofs  in  2  byte offset, address bits [1:0].
REQ-009 width  in  2  00 none, 01 byte, 10 halfword, 11 word.
REQ-010 sign  in  1  sign-extend sub-word loads.
REQ-011 tag  in  TAG_W  destination tag, returned with data.
REQ-012 data_ok  in  1  bus returns data for oldest outstanding request.
REQ-013 rdata  in  32  raw bus read word.
REQ-014 rd_valid  out  1  one-cycle completion pulse.
REQ-015 rd_data  out  32  aligned/extended load result.
REQ-016 rd_tag  out  TAG_W  tag of completed request.
REQ-017 rd_we  out  1  completed request was a store.
REQ-018 rd_misalign  out  1  completed load was misaligned (see Configuration).
REQ-019 full  out  1  count==DEPTH; upstream SHALL NOT assert req.
REQ-020 data_pending  out  1  count!=0.
REQ-021 count  out  $clog2(DEPTH)+1  outstanding requests.
REQ-022 err  out  1  sticky protocol-violation flag.

Function
REQ-023 Queue SHALL be in-order FIFO of {we, ofs, width, sign, tag}; enqueue at tail on req&&addr_ok, dequeue head on data_ok.
REQ-024 Simultaneous enqueue and dequeue SHALL both take effect; count unchanged.
REQ-025 Enqueue while full without same-cycle data_ok SHALL be dropped and set err; with same-cycle data_ok SHALL be accepted.
REQ-026 data_ok while empty SHALL be ignored (no rd_valid) and set err.
REQ-027 Pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from count, not pointer equality.
REQ-028 rd_valid SHALL assert the cycle after data_ok, for exactly one cycle; rd_tag/rd_we from head entry.
REQ-029 Loads: width 01 SHALL select byte ofs, zero/sign-extend per sign; 10 SHALL select halfword ofs[1] (ofs 00 low, 10 high); 11 SHALL pass rdata; 00 SHALL yield 0.
REQ-030 Stores: rd_valid SHALL pulse, rd_data SHALL hold its previous value.
REQ-031 rd_data/rd_tag/rd_we/rd_misalign SHALL hold between pulses.
REQ-032 data_pending, full, count SHALL be registered-state decodes, valid the cycle after the update.

Reset
REQ-033 rst low SHALL immediately clear count, pointers, err, rd_valid, rd_data, rd_tag, rd_we, rd_misalign; full=0, data_pending=0.
REQ-034 Requests outstanding at reset SHALL be discarded; post-reset data_ok with empty queue SHALL set err.

Configuration
REQ-035 Macro LRQ_MISALIGN_CHK_EN, when defined: halfword load with ofs[0]=1 or word load with ofs!=00 SHALL return rd_data=0, rd_misalign=1 on its pulse.
REQ-036 Without LRQ_MISALIGN_CHK_EN: misaligned halfword SHALL return 0, word SHALL ignore ofs and pass rdata, rd_misalign tied 0.

Verification
REQ-037 Reset; enqueue LB ofs=11 sign=1 tag=3; data_ok rdata=0x80_12_34_56 -> next cycle rd_valid=1, rd_data=0xFFFFFF80, rd_tag=3, count 0.
REQ-038 Enqueue 4 loads (tags 1..4) back-to-back, DEPTH=4 -> full=1, count=4; four data_ok -> rd_tag 1,2,3,4 in order, data_pending falls after last.
REQ-039 Full queue, req&&addr_ok with data_ok same cycle -> accepted, count stays 4, err=0; without data_ok -> dropped, err=1.
REQ-040 data_ok with empty queue -> no rd_valid, err=1 sticky until reset.
REQ-041 LHU ofs=10 rdata=0x8001_0000 -> rd_data=0x00008001; LW ofs=01 -> with macro rd_data=0, rd_misalign=1; without macro rd_data=rdata, rd_misalign=0.
REQ-042 Three outstanding, rst pulsed low mid-cycle -> outputs clear asynchronously, count=0; following data_ok sets err.
